// File: rtl/vj_pkg.sv
// Shared types and constants for the Viola-Jones front-end stages.
// Pixel width and default window dimensions live here so every stage agrees.
package vj_pkg;

    localparam int PIX_W      = 32;
    localparam int DEF_WIDTH  = 10;
    localparam int DEF_HEIGHT = 10;

    typedef logic [PIX_W-1:0] pixel_t;

endpackage : vj_pkg

// File: rtl/int_img_prefix.sv
// One channel of a 2D inclusive prefix sum over an H x W image, combinational.
// Row prefix sums are accumulated down each column; all arithmetic wraps mod 2^32.
module int_img_prefix
    import vj_pkg::*;
#(
    parameter int H = DEF_HEIGHT,
    parameter int W = DEF_WIDTH
) (
    input  pixel_t [H-1:0][W-1:0] in_img,
    output pixel_t [H-1:0][W-1:0] sum_img
);

    pixel_t           row_acc;
    pixel_t [W-1:0]   col_acc;

    always_comb begin
        row_acc = '0;
        col_acc = '0;
        sum_img = '0;
        for (int i = 0; i < H; i++) begin
            row_acc = '0;
            for (int j = 0; j < W; j++) begin
                // row_acc is S[i][j]; col_acc[j] carries out[i-1][j] from the previous row
                row_acc    = row_acc + in_img[i][j];
                col_acc[j] = col_acc[j] + row_acc;
                sum_img[i][j] = col_acc[j];
            end
        end
    end

endmodule : int_img_prefix

// File: rtl/int_img_calc.sv
// Integral image and squared integral image of one window, one image per clock.
// Squarers and both prefix channels are combinational; only the outputs are registered.
module int_img_calc
    import vj_pkg::*;
#(
    parameter int WIDTH_LIMIT  = DEF_WIDTH,
    parameter int HEIGHT_LIMIT = DEF_HEIGHT
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic [HEIGHT_LIMIT-1:0][WIDTH_LIMIT-1:0][PIX_W-1:0] input_img,
    output logic [HEIGHT_LIMIT-1:0][WIDTH_LIMIT-1:0][PIX_W-1:0] output_img,
    output logic [HEIGHT_LIMIT-1:0][WIDTH_LIMIT-1:0][PIX_W-1:0] output_img_sq
);

    pixel_t [HEIGHT_LIMIT-1:0][WIDTH_LIMIT-1:0] sq_img;
    pixel_t [HEIGHT_LIMIT-1:0][WIDTH_LIMIT-1:0] out_img_d;
    pixel_t [HEIGHT_LIMIT-1:0][WIDTH_LIMIT-1:0] out_sq_d;
    pixel_t [HEIGHT_LIMIT-1:0][WIDTH_LIMIT-1:0] out_img_q;
    pixel_t [HEIGHT_LIMIT-1:0][WIDTH_LIMIT-1:0] out_sq_q;

    // Full 32x32 product, only the low word is kept
    for (genvar gi = 0; gi < HEIGHT_LIMIT; gi++) begin : g_row
        for (genvar gj = 0; gj < WIDTH_LIMIT; gj++) begin : g_col
            assign sq_img[gi][gj] = input_img[gi][gj] * input_img[gi][gj];
        end
    end

    int_img_prefix #(
        .H(HEIGHT_LIMIT),
        .W(WIDTH_LIMIT)
    ) u_prefix_img (
        .in_img (input_img),
        .sum_img(out_img_d)
    );

    int_img_prefix #(
        .H(HEIGHT_LIMIT),
        .W(WIDTH_LIMIT)
    ) u_prefix_sq (
        .in_img (sq_img),
        .sum_img(out_sq_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_img_q <= '0;
            out_sq_q  <= '0;
        end else begin
            out_img_q <= out_img_d;
            out_sq_q  <= out_sq_d;
        end
    end

    assign output_img    = out_img_q;
    assign output_img_sq = out_sq_q;

endmodule : int_img_calc

// File: tb/tb_int_img_calc.sv
// Directed self-checking bench for int_img_calc on a 10x10 window.
// Each task drives one scenario and compares outputs against hand-derived values.
module tb_int_img_calc;

    localparam int H = 10;
    localparam int W = 10;

    logic                         clk;
    logic                         rst;
    logic [H-1:0][W-1:0][31:0]    img;
    logic [H-1:0][W-1:0][31:0]    out_img;
    logic [H-1:0][W-1:0][31:0]    out_sq;

    int total;
    int bad;

    int_img_calc #(
        .WIDTH_LIMIT (W),
        .HEIGHT_LIMIT(H)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .input_img    (img),
        .output_img   (out_img),
        .output_img_sq(out_sq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        for (int k = 0; k < 3; k++) @(posedge clk);
        #1;
        for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++) begin
                total++;
                if (out_img[i][j] !== 32'd0 || out_sq[i][j] !== 32'd0) begin
                    bad++;
                    $display("FAIL reset_state [%0d][%0d] got img=%0d sq=%0d want 0 0", i, j, out_img[i][j], out_sq[i][j]);
                end
            end
        $display("xact reset_state checked");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_const(input logic [31:0] v, input string name);
        logic [31:0] e, es;
        @(negedge clk);
        for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++) img[i][j] = v;
        @(posedge clk);
        #1;
        for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++) begin
                e  = v * 32'((i + 1) * (j + 1));
                es = (v * v) * 32'((i + 1) * (j + 1));
                total++;
                if (out_img[i][j] !== e) begin
                    bad++;
                    $display("FAIL %s_img [%0d][%0d] got %0d want %0d", name, i, j, out_img[i][j], e);
                end
                total++;
                if (out_sq[i][j] !== es) begin
                    bad++;
                    $display("FAIL %s_sq [%0d][%0d] got %0d want %0d", name, i, j, out_sq[i][j], es);
                end
            end
        $display("xact %s v=%h corner img=%0d sq=%0d", name, v, out_img[H-1][W-1], out_sq[H-1][W-1]);
    endtask

    task automatic test_single_pixel();
        logic [31:0] e, es;
        @(negedge clk);
        img = '0;
        img[3][4] = 32'd5;
        @(posedge clk);
        #1;
        for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++) begin
                e  = (i >= 3 && j >= 4) ? 32'd5 : 32'd0;
                es = (i >= 3 && j >= 4) ? 32'd25 : 32'd0;
                total++;
                if (out_img[i][j] !== e || out_sq[i][j] !== es) begin
                    bad++;
                    $display("FAIL single_pixel [%0d][%0d] got img=%0d sq=%0d want %0d %0d", i, j, out_img[i][j], out_sq[i][j], e, es);
                end
            end
        $display("xact single_pixel corner img=%0d sq=%0d", out_img[H-1][W-1], out_sq[H-1][W-1]);
    endtask

    task automatic test_ramp();
        logic [31:0] e, es;
        @(negedge clk);
        for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++) img[i][j] = 32'(i * 10 + j);
        @(posedge clk);
        #1;
        for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++) begin
                e  = '0;
                es = '0;
                for (int r = 0; r <= i; r++)
                    for (int c = 0; c <= j; c++) begin
                        e  = e + 32'(r * 10 + c);
                        es = es + 32'((r * 10 + c) * (r * 10 + c));
                    end
                total++;
                if (out_img[i][j] !== e || out_sq[i][j] !== es) begin
                    bad++;
                    $display("FAIL ramp [%0d][%0d] got img=%0d sq=%0d want %0d %0d", i, j, out_img[i][j], out_sq[i][j], e, es);
                end
            end
        total++;
        if (out_img[0][0] !== 32'd0 || out_img[0][9] !== 32'd45 || out_img[9][0] !== 32'd450) begin
            bad++;
            $display("FAIL ramp_edges got %0d %0d %0d want 0 45 450", out_img[0][0], out_img[0][9], out_img[9][0]);
        end
        $display("xact ramp corner img=%0d sq=%0d", out_img[H-1][W-1], out_sq[H-1][W-1]);
    endtask

    task automatic test_async_reset();
        test_const(32'd2, "pre_reset");
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++) begin
                total++;
                if (out_img[i][j] !== 32'd0 || out_sq[i][j] !== 32'd0) begin
                    bad++;
                    $display("FAIL async_reset [%0d][%0d] got img=%0d sq=%0d want 0 0", i, j, out_img[i][j], out_sq[i][j]);
                end
            end
        @(posedge clk);
        #1;
        total++;
        if (out_img[H-1][W-1] !== 32'd0) begin
            bad++;
            $display("FAIL reset_hold got %0d want 0", out_img[H-1][W-1]);
        end
        $display("xact async_reset outputs cleared");
        @(negedge clk);
        rst = 1'b0;
        test_const(32'd2, "post_reset");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++) img[i][j] = 32'd1;
        @(posedge clk);
        #1;
        total++;
        if (out_img[9][9] !== 32'd100 || out_sq[9][9] !== 32'd100) begin
            bad++;
            $display("FAIL b2b_first got img=%0d sq=%0d want 100 100", out_img[9][9], out_sq[9][9]);
        end
        $display("xact b2b_first img=%0d sq=%0d", out_img[9][9], out_sq[9][9]);
        @(negedge clk);
        for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++) img[i][j] = 32'd3;
        total++;
        if (out_img[9][9] !== 32'd100) begin
            bad++;
            $display("FAIL b2b_latency got %0d want 100", out_img[9][9]);
        end
        @(posedge clk);
        #1;
        total++;
        if (out_img[9][9] !== 32'd300 || out_sq[9][9] !== 32'd900 || out_img[0][0] !== 32'd3) begin
            bad++;
            $display("FAIL b2b_second got img=%0d sq=%0d [0][0]=%0d want 300 900 3", out_img[9][9], out_sq[9][9], out_img[0][0]);
        end
        $display("xact b2b_second img=%0d sq=%0d", out_img[9][9], out_sq[9][9]);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        img   = '0;
        rst   = 1'b1;
        test_reset();
        test_const(32'd2, "all_twos");
        test_single_pixel();
        test_ramp();
        test_const(32'hFFFF_FFFF, "wrap");
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_int_img_calc
